// File: rtl/vga_display_controller.sv
// VGA raster timing generator with a registered sync/colour output stage.
// The output stage is one pixel behind the counters, so sync and colour stay aligned.
module vga_display_controller #(
   parameter int CLK_DIV      = 4,
   parameter int H_TOTAL      = 800,
   parameter int H_SYNC       = 96,
   parameter int H_DISP_START = 144,
   parameter int H_DISP_END   = 784,
   parameter int V_TOTAL      = 525,
   parameter int V_SYNC       = 2,
   parameter int V_DISP_START = 35,
   parameter int V_DISP_END   = 515
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] rgb,
   output logic [9:0]  hCount,
   output logic [9:0]  vCount,
   output logic        bright,
   output logic        pix_en,
   output logic        frame_tick,
   output logic [7:0]  frame_count,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div;
   logic          adv;
   logic          h_last;
   logic          v_last;
   logic          hs_c;
   logic          vs_c;
   logic [11:0]   col_c;

   assign adv    = (div == DW'(CLK_DIV - 1));
   assign h_last = (hCount == 10'(H_TOTAL - 1));
   assign v_last = (vCount == 10'(V_TOTAL - 1));

   assign bright = (hCount >= 10'(H_DISP_START))
                && (hCount <  10'(H_DISP_END))
                && (vCount >= 10'(V_DISP_START))
                && (vCount <  10'(V_DISP_END));

   assign hs_c  = ~(hCount < 10'(H_SYNC));
   assign vs_c  = ~(vCount < 10'(V_SYNC));
   assign col_c = bright ? rgb : 12'h000;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div    <= '0;
         pix_en <= 1'b0;
      end else begin
         pix_en <= adv;
         if (adv) div <= '0;
         else     div <= div + DW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hCount <= '0;
         vCount <= '0;
      end else if (adv) begin
         if (h_last) begin
            hCount <= '0;
            if (v_last) vCount <= '0;
            else        vCount <= vCount + 10'd1;
         end else begin
            hCount <= hCount + 10'd1;
         end
      end
   end

   // Loaded from the pre-advance counters: one pixel behind hCount/vCount.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vga_hsync <= 1'b1;
         vga_vsync <= 1'b1;
         vga_r     <= '0;
         vga_g     <= '0;
         vga_b     <= '0;
      end else if (adv) begin
         vga_hsync <= hs_c;
         vga_vsync <= vs_c;
         vga_r     <= col_c[11:8];
         vga_g     <= col_c[7:4];
         vga_b     <= col_c[3:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_tick  <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_tick <= adv && h_last && v_last;
         if (adv && h_last && v_last)
            frame_count <= frame_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_vga_display_controller.sv
// Bench for vga_display_controller: two shrunken-timing builds (CLK_DIV 3 and 1)
// checked every cycle against an elapsed-clock arithmetic model.
module tb_vga_display_controller;

   localparam int HT = 10;
   localparam int HS = 2;
   localparam int HDS = 3;
   localparam int HDE = 9;
   localparam int VT = 7;
   localparam int VS = 2;
   localparam int VDS = 2;
   localparam int VDE = 6;
   localparam int FR = HT * VT;
   localparam int D0 = 3;
   localparam int D1 = 1;

   typedef struct packed {
      logic [9:0]  h;
      logic [9:0]  v;
      logic        bright;
      logic        pe;
      logic        ft;
      logic [7:0]  fc;
      logic        hs;
      logic        vs;
      logic [11:0] col;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [11:0] rgb;

   logic [9:0]  h0, v0, h1, v1;
   logic        br0, pe0, ft0, hs0, vs0;
   logic        br1, pe1, ft1, hs1, vs1;
   logic [7:0]  fc0, fc1;
   logic [3:0]  r0, g0, b0, r1, g1, b1;

   int          n_chk;
   int          n_fail;
   int          ncyc;
   logic [11:0] lrgb0;
   logic [11:0] lrgb1;
   logic        done;

   vga_display_controller #(
      .CLK_DIV(D0), .H_TOTAL(HT), .H_SYNC(HS),
      .H_DISP_START(HDS), .H_DISP_END(HDE),
      .V_TOTAL(VT), .V_SYNC(VS),
      .V_DISP_START(VDS), .V_DISP_END(VDE)
   ) u0 (
      .clk(clk), .rst(rst), .rgb(rgb),
      .hCount(h0), .vCount(v0), .bright(br0),
      .pix_en(pe0), .frame_tick(ft0),
      .frame_count(fc0),
      .vga_hsync(hs0), .vga_vsync(vs0),
      .vga_r(r0), .vga_g(g0), .vga_b(b0)
   );

   vga_display_controller #(
      .CLK_DIV(D1), .H_TOTAL(HT), .H_SYNC(HS),
      .H_DISP_START(HDS), .H_DISP_END(HDE),
      .V_TOTAL(VT), .V_SYNC(VS),
      .V_DISP_START(VDS), .V_DISP_END(VDE)
   ) u1 (
      .clk(clk), .rst(rst), .rgb(rgb),
      .hCount(h1), .vCount(v1), .bright(br1),
      .pix_en(pe1), .frame_tick(ft1),
      .frame_count(fc1),
      .vga_hsync(hs1), .vga_vsync(vs1),
      .vga_r(r1), .vga_g(g1), .vga_b(b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic in_win(input int h, input int v);
      return (h >= HDS) && (h < HDE) && (v >= VDS) && (v < VDE);
   endfunction

   // Position is a pure function of clocks elapsed since reset release.
   function automatic exp_t model(input int n, input int d,
                                  input logic [11:0] lr);
      exp_t e;
      int a, p, ph, pv;
      a = n / d;
      e.h = 10'(a % HT);
      e.v = 10'((a / HT) % VT);
      e.bright = in_win(a % HT, (a / HT) % VT);
      e.pe = (n >= 1) && (n % d == 0);
      e.ft = e.pe && (a % FR == 0);
      e.fc = 8'((a / FR) % 256);
      if (a == 0) begin
         e.hs = 1'b1;
         e.vs = 1'b1;
         e.col = 12'h000;
      end else begin
         p = a - 1;
         ph = p % HT;
         pv = (p / HT) % VT;
         e.hs = (ph >= HS);
         e.vs = (pv >= VS);
         e.col = in_win(ph, pv) ? lr : 12'h000;
      end
      return e;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ncyc <= 0;
      end else begin
         if ((ncyc + 1) % D0 == 0) lrgb0 <= rgb;
         if ((ncyc + 1) % D1 == 0) lrgb1 <= rgb;
         ncyc <= ncyc + 1;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!done) begin
         e = model(ncyc, D0, lrgb0);
         chk("d3 hCount", 32'(h0), 32'(e.h));
         chk("d3 vCount", 32'(v0), 32'(e.v));
         chk("d3 bright", 32'(br0), 32'(e.bright));
         chk("d3 pix_en", 32'(pe0), 32'(e.pe));
         chk("d3 frame_tick", 32'(ft0), 32'(e.ft));
         chk("d3 frame_count", 32'(fc0), 32'(e.fc));
         chk("d3 hsync", 32'(hs0), 32'(e.hs));
         chk("d3 vsync", 32'(vs0), 32'(e.vs));
         chk("d3 rgb", 32'({r0, g0, b0}), 32'(e.col));
         e = model(ncyc, D1, lrgb1);
         chk("d1 hCount", 32'(h1), 32'(e.h));
         chk("d1 vCount", 32'(v1), 32'(e.v));
         chk("d1 bright", 32'(br1), 32'(e.bright));
         chk("d1 pix_en", 32'(pe1), 32'(e.pe));
         chk("d1 frame_tick", 32'(ft1), 32'(e.ft));
         chk("d1 frame_count", 32'(fc1), 32'(e.fc));
         chk("d1 hsync", 32'(hs1), 32'(e.hs));
         chk("d1 vsync", 32'(vs1), 32'(e.vs));
         chk("d1 rgb", 32'({r1, g1, b1}), 32'(e.col));
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2 rgb = 12'($urandom);
      end
   end

   initial begin
      int cnt;
      logic found;
      n_chk = 0;
      n_fail = 0;
      done = 1'b0;
      rst = 1'b0;
      rgb = 12'h000;
      lrgb0 = 12'h000;
      lrgb1 = 12'h000;

      repeat (5) @(posedge clk);
      #2;
      chk("reset hsync", 32'(hs0), 32'd1);
      chk("reset vsync", 32'(vs0), 32'd1);
      chk("reset hCount", 32'(h0), 32'd0);
      rst = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("first pix_en d3", 32'(pe0), 32'd1);
      chk("first hCount d3", 32'(h0), 32'd1);
      chk("hCount d1 at 3", 32'(h1), 32'd3);

      repeat (27) @(posedge clk);
      #1;
      chk("line wrap h", 32'(h0), 32'd0);
      chk("line wrap v", 32'(v0), 32'd1);

      repeat (180) @(posedge clk);
      #1;
      chk("frame tick d3", 32'(ft0), 32'd1);
      chk("frame count d3", 32'(fc0), 32'd1);
      chk("frame tick d1", 32'(ft1), 32'd1);
      chk("frame count d1", 32'(fc1), 32'd3);

      found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(posedge clk);
         #1;
         if (h0 == 10'd2 && v0 == 10'd1) found = 1'b1;
      end
      chk("reach mid-frame", 32'(found), 32'd1);

      #1 rst = 1'b0;
      #1;
      chk("async hsync", 32'(hs0), 32'd1);
      chk("async vsync", 32'(vs0), 32'd1);
      chk("async hCount", 32'(h0), 32'd0);
      chk("async vCount", 32'(v0), 32'd0);
      @(posedge clk);
      #2 rst = 1'b1;

      cnt = 0;
      found = 1'b0;
      while (cnt < 400 && !found) begin
         @(posedge clk);
         cnt++;
         #1;
         if (ft0) found = 1'b1;
      end
      chk("tick after reset", 32'(cnt), 32'(FR * D0));

      repeat (255 * FR * D0) @(posedge clk);
      #1;
      chk("256 frames tick", 32'(ft0), 32'd1);
      chk("256 frames d3", 32'(fc0), 32'd0);
      chk("768 frames d1", 32'(fc1), 32'd0);

      @(negedge clk);
      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
